// File: rtl/uart_mem_dump_pkg.sv
// Shared UART framing constants, FSM encoding and divider helper
// for the program-link transmitter and receiver.
package uart_mem_dump_pkg;

  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_LATCH,
    S_SEND
  } state_t;

  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_mem_dump_tx.sv
// 8N1 byte serializer: owns the baud counter and the shift register.
// The start bit is on txd the cycle after load.
module uart_tx_byte
  import uart_mem_dump_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       ready
);

  localparam int CNTW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNTW-1:0] cnt;
  logic [3:0]      idx;
  logic [7:0]      sh;
  logic            active;

  always_ff @(posedge clk) begin
    if (reset) begin
      txd    <= 1'b1;
      active <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
    end else if (load && !active) begin
      txd    <= START_BIT;
      sh     <= data;
      idx    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (cnt == CNTW'(DIV - 1)) begin
        cnt <= '0;
        if (idx == 4'(FRAME_BITS - 1)) begin
          active <= 1'b0;
        end else begin
          idx <= idx + 4'd1;
          // idx 8 is d7; the following bit is the stop bit
          if (idx == 4'(FRAME_BITS - 2)) begin
            txd <= STOP_BIT;
          end else begin
            txd <= sh[0];
            sh  <= {1'b0, sh[7:1]};
          end
        end
      end else begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

  assign ready = !active;

endmodule

// File: rtl/uart_mem_dump.sv
// Dumps a RAM window over the UART link, borrowing the RAM through
// the ask_for_ram arbiter for one byte fetch at a time.
module uart_mem_dump
  import uart_mem_dump_pkg::*;
#(
  parameter int                    CLK_HZ     = 25_000_000,
  parameter int                    BAUD       = 57600,
  parameter int                    ADDR_WIDTH = 11,
  parameter logic [ADDR_WIDTH-1:0] DUMP_START = 11'h200,
  parameter int                    DUMP_LEN   = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  ask_for_ram,
  input  logic                  ram_granted,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [7:0]            rdata,
  output logic                  serial_txd,
  output logic                  busy,
  output logic                  done
);

  localparam int   DIV   = uart_div(CLK_HZ, BAUD);
  localparam int   CW    = $clog2(2**ADDR_WIDTH + 1);
  localparam logic EMPTY = (DUMP_LEN == 0);

  state_t                state;
  state_t                state_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [CW-1:0]         count;
  logic                  zero_done;
  logic                  tx_ready;
  logic                  load;
  logic                  start_ok;
  logic                  last;

  assign start_ok = (state == S_IDLE) && start;
  assign last     = (count == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start && !EMPTY) state_n = S_REQ;
      S_REQ:   if (ram_granted) state_n = S_ADDR;
      S_ADDR:  state_n = ram_granted ? S_LATCH : S_REQ;
      S_LATCH: state_n = ram_granted ? S_SEND : S_REQ;
      S_SEND:  if (tx_ready) state_n = last ? S_IDLE : S_REQ;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= DUMP_START;
      raddr_q   <= DUMP_START;
      count     <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= start_ok && EMPTY;
      if (start_ok) begin
        addr  <= DUMP_START;
        count <= CW'(DUMP_LEN);
      end
      if (state == S_ADDR) raddr_q <= addr;
      // advance only once the frame is fully out, so a lost grant retries
      if (state == S_SEND && tx_ready) begin
        addr  <= addr + 1'b1;
        count <= count - 1'b1;
      end
    end
  end

  always_comb begin
    ask_for_ram = (state == S_REQ) || (state == S_ADDR)
               || (state == S_LATCH);
    busy        = (state != S_IDLE) || zero_done;
    done        = ((state == S_SEND) && tx_ready && last) || zero_done;
    raddr       = (state == S_ADDR) ? addr : raddr_q;
    load        = (state == S_LATCH) && ram_granted;
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_tx (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .data (rdata),
    .txd  (serial_txd),
    .ready(tx_ready)
  );

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench: four dumper instances with different windows share
// one RAM model and one arbiter model.
module tb_uart_mem_dump;

  localparam int DIV = 434;

  logic        clk = 1'b0;
  logic        reset;
  logic        grant;
  logic        start [4];
  logic        ask   [4];
  logic [10:0] raddr [4];
  logic [7:0]  rdata [4];
  logic        txd   [4];
  logic        busy  [4];
  logic        done  [4];

  logic [7:0]  mem [0:2047];

  int n_chk = 0;
  int n_fail = 0;
  int gmode = 0;
  bit drop_pend = 1'b0;
  int wcnt = 0;
  int gcyc = 0;
  int done_cnt [4] = '{default: 0};
  int busy_gap = 0;
  bit watch = 1'b0;
  int hi_err = 0;

  always #5 clk = ~clk;

  uart_mem_dump #(.DUMP_LEN(1)) d0 (
    .clk(clk), .reset(reset), .start(start[0]), .ask_for_ram(ask[0]),
    .ram_granted(grant), .raddr(raddr[0]), .rdata(rdata[0]),
    .serial_txd(txd[0]), .busy(busy[0]), .done(done[0]));

  uart_mem_dump #(.DUMP_LEN(4)) d1 (
    .clk(clk), .reset(reset), .start(start[1]), .ask_for_ram(ask[1]),
    .ram_granted(grant), .raddr(raddr[1]), .rdata(rdata[1]),
    .serial_txd(txd[1]), .busy(busy[1]), .done(done[1]));

  uart_mem_dump #(.DUMP_START(11'h7FE), .DUMP_LEN(4)) d2 (
    .clk(clk), .reset(reset), .start(start[2]), .ask_for_ram(ask[2]),
    .ram_granted(grant), .raddr(raddr[2]), .rdata(rdata[2]),
    .serial_txd(txd[2]), .busy(busy[2]), .done(done[2]));

  uart_mem_dump #(.DUMP_LEN(0)) d3 (
    .clk(clk), .reset(reset), .start(start[3]), .ask_for_ram(ask[3]),
    .ram_granted(grant), .raddr(raddr[3]), .rdata(rdata[3]),
    .serial_txd(txd[3]), .busy(busy[3]), .done(done[3]));

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) rdata[i] <= mem[raddr[i]];
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (done[i] === 1'b1) done_cnt[i]++;
    if (watch && busy[1] !== 1'b1) busy_gap++;
    if (gmode == 1 && ask[1] && !grant && txd[1] !== 1'b1) hi_err++;
  end

  // arbiter: tied granted, or 100-cycle delay per ask plus one LATCH drop
  initial begin
    grant = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (gmode == 0) begin
        grant = 1'b1;
      end else if (ask[1] !== 1'b1) begin
        grant = 1'b0;
        wcnt = 0;
      end else if (!grant) begin
        wcnt++;
        if (wcnt >= 100) begin
          grant = 1'b1;
          gcyc = 0;
        end
      end else begin
        gcyc++;
        if (drop_pend && gcyc == 2) begin
          grant = 1'b0;
          drop_pend = 1'b0;
          wcnt = 0;
        end
      end
    end
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: run exceeded 95000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_low(input int k, output bit ok);
    int t = 0;
    while (txd[k] !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 3000);
    chk("start_bit_seen", 32'(ok), 1);
  endtask

  task automatic rx_byte(input int k, output logic [7:0] b);
    bit ok;
    b = '0;
    wait_low(k, ok);
    if (!ok) return;
    repeat (DIV / 2) @(negedge clk);
    chk("rx_start_mid", 32'(txd[k]), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      b[i] = txd[k];
    end
    repeat (DIV) @(negedge clk);
    chk("rx_stop", 32'(txd[k]), 1);
  endtask

  task automatic wait_done(input int k, input string tag);
    int t = 0;
    while (done[k] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(done[k]), 1);
  endtask

  logic [7:0] b;
  logic [9:0] frame;
  int errs [10];
  int early;
  int dc;
  bit ok;
  logic [7:0]  exp_b [4];
  logic [10:0] exp_a [4];

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) start[i] = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
    mem[11'h200] = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd[0]), 1);
    chk("rst_ask", 32'(ask[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    chk("rst_raddr", 32'(raddr[0]), 32'h200);
    chk("rst_raddr_d2", 32'(raddr[2]), 32'h7FE);
    reset = 1'b0;

    // 1: single byte A5, exact bit timing
    frame = 10'b11_0100_1010 ^ 10'b00_0000_0000;
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) errs[i] = 0;
    early = 0;
    pulse_start(0);
    chk("t1_ask_c1", 32'(ask[0]), 1);
    chk("t1_busy", 32'(busy[0]), 1);
    @(negedge clk);
    chk("t1_ask_c2", 32'(ask[0]), 1);
    chk("t1_raddr", 32'(raddr[0]), 32'h200);
    @(negedge clk);
    chk("t1_ask_c3", 32'(ask[0]), 1);
    @(negedge clk);
    chk("t1_ask_off", 32'(ask[0]), 0);
    for (int i = 0; i < 10 * DIV; i++) begin
      if (i > 0) @(negedge clk);
      if (txd[0] !== frame[i / DIV]) errs[i / DIV]++;
      if (done[0] === 1'b1) early++;
    end
    for (int i = 0; i < 10; i++)
      chk($sformatf("t1_bit%0d_errs", i), 32'(errs[i]), 0);
    chk("t1_no_early_done", 32'(early), 0);
    @(negedge clk);
    chk("t1_done", 32'(done[0]), 1);
    @(negedge clk);
    chk("t1_done_1cyc", 32'(done[0]), 0);
    chk("t1_busy_end", 32'(busy[0]), 0);

    // 2: four bytes in order, busy throughout, one done
    mem[11'h200] = 8'h01;
    mem[11'h201] = 8'h02;
    mem[11'h202] = 8'h03;
    mem[11'h203] = 8'h04;
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
    pulse_start(1);
    watch = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_byte(1, b);
      chk($sformatf("t2_byte%0d", i), 32'(b), 32'(exp_b[i]));
    end
    wait_done(1, "t2_done_seen");
    watch = 1'b0;
    @(negedge clk);
    chk("t2_busy_end", 32'(busy[1]), 0);
    repeat (10) @(negedge clk);
    chk("t2_busy_gaps", 32'(busy_gap), 0);
    chk("t2_done_count", 32'(done_cnt[1]), 1);

    // 3: slow arbiter plus one grant drop in LATCH
    mem[11'h200] = 8'h3C;
    mem[11'h201] = 8'hC3;
    mem[11'h202] = 8'h5A;
    mem[11'h203] = 8'h81;
    exp_b = '{8'h3C, 8'hC3, 8'h5A, 8'h81};
    dc = done_cnt[1];
    gmode = 1;
    drop_pend = 1'b1;
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      rx_byte(1, b);
      chk($sformatf("t3_byte%0d", i), 32'(b), 32'(exp_b[i]));
    end
    wait_done(1, "t3_done_seen");
    repeat (5) @(negedge clk);
    chk("t3_drop_used", 32'(drop_pend), 0);
    chk("t3_txd_idle_wait", 32'(hi_err), 0);
    chk("t3_done_count", 32'(done_cnt[1] - dc), 1);
    gmode = 0;
    repeat (3) @(negedge clk);

    // 4: address wrap from 7FE
    mem[11'h7FE] = 8'h11;
    mem[11'h7FF] = 8'h22;
    mem[11'h000] = 8'h33;
    mem[11'h001] = 8'h44;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    pulse_start(2);
    for (int i = 0; i < 4; i++) begin
      rx_byte(2, b);
      chk($sformatf("t4_raddr%0d", i), 32'(raddr[2]), 32'(exp_a[i]));
      chk($sformatf("t4_byte%0d", i), 32'(b), 32'(exp_b[i]));
    end
    wait_done(2, "t4_done_seen");

    // 5: start ignored while busy, reset in frame 2, restart
    repeat (3) @(negedge clk);
    pulse_start(1);
    rx_byte(1, b);
    chk("t5_byte0", 32'(b), 32'h3C);
    pulse_start(1);
    wait_low(1, ok);
    chk("t5_raddr_f2", 32'(raddr[1]), 32'h201);
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    dc = done_cnt[1];
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_rst_txd", 32'(txd[1]), 1);
    chk("t5_rst_ask", 32'(ask[1]), 0);
    chk("t5_rst_busy", 32'(busy[1]), 0);
    chk("t5_rst_done", 32'(done[1]), 0);
    repeat (DIV) @(negedge clk);
    chk("t5_no_done", 32'(done_cnt[1] - dc), 0);
    chk("t5_txd_idle", 32'(txd[1]), 1);
    pulse_start(1);
    rx_byte(1, b);
    chk("t5_restart_byte", 32'(b), 32'h3C);
    chk("t5_restart_raddr", 32'(raddr[1]), 32'h200);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // 6: empty dump
    dc = done_cnt[3];
    pulse_start(3);
    chk("t6_done", 32'(done[3]), 1);
    chk("t6_busy", 32'(busy[3]), 1);
    chk("t6_ask", 32'(ask[3]), 0);
    chk("t6_txd", 32'(txd[3]), 1);
    @(negedge clk);
    chk("t6_done_1cyc", 32'(done[3]), 0);
    chk("t6_busy_end", 32'(busy[3]), 0);
    repeat (10) @(negedge clk);
    chk("t6_ask_never", 32'(ask[3]), 0);
    chk("t6_done_count", 32'(done_cnt[3] - dc), 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
